// File: rtl/comp_edge_capture.sv
// Comparator edge capture for single-slope column ADCs: per-channel sync/glitch
// filter, first-edge detection per frame, and ramp-code latching with overflow.
module comp_edge_capture #(
    parameter int unsigned NUM_PIXELS  = 4,
    parameter int unsigned CODE_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             edge_sel,
    input  logic                             frame_end,
    input  logic [CODE_WIDTH-1:0]            ramp_code,
    input  logic [NUM_PIXELS-1:0]            comp,
    output logic [NUM_PIXELS-1:0]            enable,
    output logic [NUM_PIXELS*CODE_WIDTH-1:0] codes,
    output logic [NUM_PIXELS-1:0]            valid,
    output logic [NUM_PIXELS-1:0]            overflow,
    output logic                             busy,
    output logic                             all_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CODE_WIDTH-1:0] CODE_ONES = {CODE_WIDTH{1'b1}};

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  edge_mode_q;
    logic [NUM_PIXELS-1:0] captured_q;
    logic [NUM_PIXELS-1:0] filt;
    logic [NUM_PIXELS-1:0] prev_filt;
    logic [NUM_PIXELS-1:0] qual_edge_c;
    logic [NUM_PIXELS-1:0] cap_c;
    logic                  start_accept_c;

    // Free-running front end: synchroniser, agreement window, hysteretic level.
    for (genvar g = 0; g < NUM_PIXELS; g++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_q;
        logic [FILTER_LEN-1:0]  win_q;
        logic                   filt_q;
        logic                   prev_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync_q <= '0;
                win_q  <= '0;
                filt_q <= 1'b0;
                prev_q <= 1'b0;
            end else begin
                sync_q[0] <= comp[g];
                for (int unsigned j = 1; j < SYNC_STAGES; j++) begin
                    sync_q[j] <= sync_q[j-1];
                end
                win_q[0] <= sync_q[SYNC_STAGES-1];
                for (int unsigned j = 1; j < FILTER_LEN; j++) begin
                    win_q[j] <= win_q[j-1];
                end
                if (&win_q) begin
                    filt_q <= 1'b1;
                end else if (~|win_q) begin
                    filt_q <= 1'b0;
                end
                prev_q <= filt_q;
            end
        end

        assign filt[g]      = filt_q;
        assign prev_filt[g] = prev_q;
    end

    // Edge qualification and capture gating.
    always_comb begin
        qual_edge_c    = '0;
        cap_c          = '0;
        start_accept_c = 1'b0;
        if (edge_mode_q) begin
            qual_edge_c = prev_filt & ~filt;
        end else begin
            qual_edge_c = ~prev_filt & filt;
        end
        if (state_q == ST_ARMED) begin
            cap_c = qual_edge_c & ~captured_q;
        end else begin
            start_accept_c = start;
        end
    end

    // Frame state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_end || (&(captured_q | cap_c))) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture datapath and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_mode_q <= 1'b0;
            captured_q  <= '0;
            enable      <= '0;
            codes       <= '0;
            valid       <= '0;
            overflow    <= '0;
            busy        <= 1'b0;
            all_done    <= 1'b0;
        end else begin
            enable   <= cap_c;
            busy     <= (state_d == ST_ARMED);
            all_done <= (state_d == ST_DONE);
            if (start_accept_c) begin
                edge_mode_q <= edge_sel;
                captured_q  <= '0;
                codes       <= '0;
                valid       <= '0;
                overflow    <= '0;
            end else if (state_q == ST_ARMED) begin
                for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
                    if (cap_c[i]) begin
                        codes[i*CODE_WIDTH +: CODE_WIDTH] <= ramp_code;
                        valid[i]      <= 1'b1;
                        captured_q[i] <= 1'b1;
                    end else if (frame_end && !captured_q[i]) begin
                        // Channel never tripped: report full-scale code.
                        codes[i*CODE_WIDTH +: CODE_WIDTH] <= CODE_ONES;
                        overflow[i]   <= 1'b1;
                        valid[i]      <= 1'b1;
                        captured_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_comp_edge_capture.sv
// Directed bench for comp_edge_capture: enable pulses are scoreboarded by a
// negedge monitor; frame status is checked directly by the stimulus.
module tb_comp_edge_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        edge_sel;
    logic        frame_end;
    logic [7:0]  ramp_code;
    logic [3:0]  comp;
    logic [3:0]  enable;
    logic [31:0] codes;
    logic [3:0]  valid;
    logic [3:0]  overflow;
    logic        busy;
    logic        all_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] codes;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    comp_edge_capture dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .edge_sel  (edge_sel),
        .frame_end (frame_end),
        .ramp_code (ramp_code),
        .comp      (comp),
        .enable    (enable),
        .codes     (codes),
        .valid     (valid),
        .overflow  (overflow),
        .busy      (busy),
        .all_done  (all_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pulse appears six counter steps after the comp change is driven.
    task automatic push_exp(input logic [3:0] mask, input logic [7:0] code);
        exp_t e;
        e.mask  = mask;
        e.codes = '0;
        e.cyc   = cyc + 6;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) e.codes[i*8 +: 8] = code;
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ramp_code = ramp_code + 8'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input logic [7:0] v);
        while (ramp_code != v) tick();
    endtask

    task automatic do_start(input logic sel);
        start     = 1'b1;
        edge_sel  = sel;
        ramp_code = 8'd0;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
    endtask

    // Monitor: every enable pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (enable != 4'b0000) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_enable: got %b expected none (cycle %0d)", enable, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("enable_mask", 64'(enable), 64'(e.mask));
                check("enable_cycle", 64'(cyc), 64'(e.cyc));
                for (int i = 0; i < 4; i++) begin
                    if (e.mask[i]) check("enable_code", 64'(codes[i*8 +: 8]), 64'(e.codes[i*8 +: 8]));
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        edge_sel  = 1'b0;
        frame_end = 1'b0;
        ramp_code = 8'd0;
        comp      = 4'b1111;
        ticks(3);
        reset = 1'b0;
        check("reset_enable", 64'(enable), 64'd0);
        check("reset_codes", 64'(codes), 64'd0);
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_overflow", 64'(overflow), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_all_done", 64'(all_done), 64'd0);
        ticks(6);

        // Falling capture, glitch rejection and overflow in one frame.
        do_start(1'b1);
        run_to(8'd20);
        comp[0] = 1'b0;
        push_exp(4'b0001, 8'd25);
        run_to(8'd30);
        comp[1] = 1'b0;
        tick();
        comp[1] = 1'b1;
        run_to(8'd40);
        check("glitch_valid", 64'(valid), 64'b0001);
        comp[1] = 1'b0;
        push_exp(4'b0010, 8'd45);
        ticks(3);
        comp[1] = 1'b1;
        run_to(8'd200);
        check("busy_before_frame_end", 64'(busy), 64'd1);
        pulse_frame_end();
        check("ovf_all_done", 64'(all_done), 64'd1);
        check("ovf_busy", 64'(busy), 64'd0);
        check("ovf_overflow", 64'(overflow), 64'b1100);
        check("ovf_valid", 64'(valid), 64'b1111);
        check("ovf_codes", 64'(codes), 64'hFFFF_2D19);

        // Early completion with all channels tripping.
        comp[0] = 1'b1;
        ticks(6);
        do_start(1'b1);
        check("restart_cleared", 64'({codes, valid, overflow}), 64'd0);
        run_to(8'd5);
        comp[0] = 1'b0;
        push_exp(4'b0001, 8'd10);
        run_to(8'd8);
        comp[1] = 1'b0;
        push_exp(4'b0010, 8'd13);
        run_to(8'd12);
        comp[2] = 1'b0;
        push_exp(4'b0100, 8'd17);
        run_to(8'd15);
        comp[3] = 1'b0;
        push_exp(4'b1000, 8'd20);
        run_to(8'd20);
        check("early_not_done_yet", 64'(all_done), 64'd0);
        tick();
        check("early_all_done", 64'(all_done), 64'd1);
        check("early_busy", 64'(busy), 64'd0);
        pulse_frame_end();
        check("early_codes_kept", 64'(codes), 64'h1411_0D0A);
        check("early_overflow", 64'(overflow), 64'b0000);
        check("early_valid", 64'(valid), 64'b1111);
        comp[0] = 1'b1;
        ticks(6);
        comp[0] = 1'b0;
        ticks(8);
        check("early_codes_after_toggle", 64'(codes), 64'h1411_0D0A);

        // Rising mode, simultaneous channels, edge coincident with frame_end.
        do_start(1'b0);
        run_to(8'd30);
        comp[0] = 1'b1;
        comp[3] = 1'b1;
        push_exp(4'b1001, 8'd35);
        run_to(8'd50);
        comp[1] = 1'b1;
        push_exp(4'b0010, 8'd55);
        run_to(8'd70);
        comp[2] = 1'b1;
        push_exp(4'b0100, 8'd75);
        run_to(8'd75);
        pulse_frame_end();
        check("rise_all_done", 64'(all_done), 64'd1);
        check("rise_overflow", 64'(overflow), 64'b0000);
        check("rise_valid", 64'(valid), 64'b1111);
        check("rise_codes", 64'(codes), 64'h234B_3723);

        // Reset mid-frame, then a clean restart.
        comp = 4'b0000;
        ticks(6);
        do_start(1'b0);
        run_to(8'd10);
        comp[0] = 1'b1;
        push_exp(4'b0001, 8'd15);
        run_to(8'd22);
        reset = 1'b1;
        comp  = 4'b0000;
        tick();
        reset = 1'b0;
        check("midreset_outputs", 64'({enable, codes, valid, overflow, busy, all_done}), 64'd0);
        ticks(6);
        do_start(1'b0);
        run_to(8'd3);
        comp[1] = 1'b1;
        push_exp(4'b0010, 8'd8);
        run_to(8'd12);
        check("restart_valid", 64'(valid), 64'b0010);
        check("restart_codes", 64'(codes), 64'h0000_0800);
        run_to(8'd20);
        pulse_frame_end();
        check("restart_overflow", 64'(overflow), 64'b1101);
        check("restart_final_codes", 64'(codes), 64'hFFFF_08FF);
        check("restart_all_done", 64'(all_done), 64'd1);

        ticks(4);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comp_edge_capture.md
# comp_edge_capture

Multi-channel comparator edge detector and code latch for single-slope column ADCs. Each pixel comparator is synchronised and glitch-filtered, and its first qualified edge of the selected polarity is detected once per conversion frame. On that edge the block emits a one-cycle enable pulse and captures the shared ramp counter code for that channel. Channels that never trip before frame end are flagged as overflow. The block sits between the analog comparator array and the pixel readout/serialiser.

## Interface
- NUM_PIXELS, 4: number of comparator channels (≥1)
- CODE_WIDTH, 8: ramp code width
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- FILTER_LEN, 2: consecutive agreeing synced samples required to change filtered level (≥1)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; arms a new frame
- edge_sel  in  1  polarity: 1 = falling (1→0), 0 = rising (0→1); sampled only on accepted start
- frame_end  in  1  one-cycle pulse; closes the armed frame
- ramp_code  in  CODE_WIDTH  shared ramp counter value
- comp  in  NUM_PIXELS  asynchronous comparator outputs
- enable  out  NUM_PIXELS  one-cycle pulse per channel on its captured edge
- codes  out  NUM_PIXELS*CODE_WIDTH  captured codes; channel i at bits [i*CODE_WIDTH +: CODE_WIDTH]
- valid  out  NUM_PIXELS  channel code is final for this frame
- overflow  out  NUM_PIXELS  channel did not trip; its code is forced to all ones
- busy  out  1  high in ARMED
- all_done  out  1  high in DONE

## Operation
- Per-channel front end runs continuously, independent of frame state:
  - sync chain of SYNC_STAGES flops feeds a FILTER_LEN-deep window.
  - filt is set to 1 when the window is all ones and to 0 when it is all zeros; otherwise it holds.
  - prev_filt is filt delayed one cycle.
- Qualified edge:
  - falling: prev_filt=1 and filt=0.
  - rising: prev_filt=0 and filt=1.
- Frame FSM has states IDLE, ARMED and DONE. Reset enters IDLE.
  - IDLE/DONE + start → ARMED. On this transition: edge_mode latches edge_sel; codes, valid, overflow and the captured flags clear to 0.
  - ARMED + start → ignored.
  - ARMED + all channels captured → DONE.
  - ARMED + frame_end → DONE. Every uncaptured channel gets code = all ones, overflow=1, valid=1.
  - IDLE/DONE + frame_end → ignored.
- Capture, while ARMED: a qualified edge on a channel with captured=0 registers enable[i]=1 for one cycle, codes[i]=ramp_code, valid[i]=1 and captured[i]=1. Later edges in the same frame are ignored.
- Outputs persist in DONE until the next accepted start.
- Edges are ignored in IDLE and DONE, and in the cycle where start is sampled.

## Timing
- Reset value of every output is 0.
- Front-end and capture latency:
  - comp changes and is stable before clk edge k.
  - enable is high in the cycle following edge k+L, where L = SYNC_STAGES+FILTER_LEN+1. Defaults give L=5.
  - codes[i] equals the ramp_code value present just before edge k+L.
- Glitch rejection: a comp pulse shorter than FILTER_LEN cycles after synchronisation produces no filt change.
- State transitions:
  - ARMED is entered at the edge that samples start; busy rises the next cycle.
  - DONE is entered at the edge that samples frame_end, or at the edge that registers the last capture; all_done rises the next cycle.
- Simultaneous events:
  - qualified edge and frame_end in the same cycle: the edge wins (normal code, overflow=0); remaining channels overflow.
  - start and frame_end in IDLE/DONE: start wins; frame_end is ignored.
  - multiple channels in the same cycle: all capture the same ramp_code with simultaneous enable pulses.
- Reset mid-frame: everything returns to IDLE with outputs 0, and the sync/filter pipeline clears to 0. Benches wait L cycles after reset before start, so the pipeline reflects comp.

## Test plan
- Basic falling capture: defaults, edge_sel=1, comp[0]=1, start, ramp_code increments by 1 each cycle, comp[0]→0 when ramp_code=20 → enable[0] for one cycle 5 cycles later, codes[0]=25, valid[0]=1.
- Glitch rejection: comp[1] dips low for 1 cycle, FILTER_LEN=2 → no enable[1], valid[1]=0. A later 3-cycle dip captures normally.
- Overflow: comp[2] held high, frame_end at ramp_code=200 → codes[2]=0xFF, overflow[2]=1, valid[2]=1, all_done=1 next cycle.
- Early completion: all 4 channels trip before frame_end → DONE after last capture. A subsequent frame_end leaves outputs unchanged. Second comp toggle produces no enable.
- Rising mode and simultaneity: edge_sel=0, channels 0 and 3 rise in the same cycle → both enable together with equal codes. Last edge coincident with frame_end → overflow=0 for that channel.
- Reset and restart: reset asserted mid-ARMED → all outputs 0 next cycle. Wait 5 cycles, then start → busy=1 and a clean capture succeeds.
